qarma128_tweak_sched: RTL and testbench

- Sequential tweak-schedule engine for the QARMA-128 datapath.
- Accepts one 128-bit tweak and emits ROUNDS successive per-round tweaks over a valid/ready stream.
- Round k is the tweak-update function applied k times, forward or inverse.
- Its output directly feeds the round-tweakey addition.
- It owns the tweak cell permutation h and the omega LFSR on the tweak path.

---
 rtl/qarma128_pkg.sv | 38 +++
 rtl/qarma128_tweak_sched_if.sv | 26 ++
 rtl/qarma128_tweak_update.sv | 36 +++
 rtl/qarma128_tweak_sched.sv | 99 +++++++++
 tb/tb_qarma128_tweak_sched.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/qarma128_pkg.sv
// qarma128_pkg
//   Shared constants and helpers for the QARMA-128 tweak/key datapaths.
//   Cell 0 is the most significant byte of a 128-bit state (bits [127:120]),
//   cell 15 the least significant (bits [7:0]).
//   H / HINV : tweak cell permutation h and its inverse (out cell i = in cell X[i]).
//   OMEGA_CELLS : cells that pass through the omega LFSR (bit 15 = cell 0).
package qarma128_pkg;

   localparam int CELL_W = 8;
   localparam int NCELLS = 16;

   typedef logic [3:0] cell_idx_t;

   localparam cell_idx_t H [NCELLS] = '{
      4'd6, 4'd5, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3,
      4'd7, 4'd12, 4'd13, 4'd4, 4'd8, 4'd9, 4'd10, 4'd11
   };

   localparam cell_idx_t HINV [NCELLS] = '{
      4'd4, 4'd5, 4'd6, 4'd7, 4'd11, 4'd1, 4'd0, 4'd8,
      4'd12, 4'd13, 4'd14, 4'd15, 4'd9, 4'd10, 4'd2, 4'd3
   };

   localparam logic [NCELLS-1:0] OMEGA_CELLS = 16'b1101_1000_1001_0100;

   typedef enum logic {ST_IDLE, ST_RUN} sched_state_e;

   // Omega LFSR step: shift right, feedback x[0]^x[2] into the MSB.
   function automatic logic [CELL_W-1:0] omega_fwd(input logic [CELL_W-1:0] x);
      return {x[0] ^ x[2], x[7:1]};
   endfunction

   // Undo omega: x[7:1] = y[6:0], and x[0] = y[7]^x[2] = y[7]^y[1].
   function automatic logic [CELL_W-1:0] omega_inv(input logic [CELL_W-1:0] y);
      return {y[6:0], y[7] ^ y[1]};
   endfunction

endpackage

// File: rtl/qarma128_tweak_sched_if.sv
// qarma128_tweak_sched_if
//   Load and round-tweak streams of the tweak scheduler.
//   load_*   : one 128-bit tweak plus direction in (valid/ready).
//   tk_*     : ROUNDS round tweaks out (valid/ready) with round index and last flag.
//   slave    : scheduler side; master : producer/consumer side.
interface qarma128_tweak_sched_if;
   logic         load_valid;
   logic         load_ready;
   logic [127:0] tweak_in;
   logic         dir;
   logic         tk_valid;
   logic         tk_ready;
   logic [127:0] tk_data;
   logic [3:0]   tk_round;
   logic         tk_last;

   modport slave (
      input  load_valid, tweak_in, dir, tk_ready,
      output load_ready, tk_valid, tk_data, tk_round, tk_last
   );

   modport master (
      output load_valid, tweak_in, dir, tk_ready,
      input  load_ready, tk_valid, tk_data, tk_round, tk_last
   );
endinterface

// File: rtl/qarma128_tweak_update.sv
// qarma128_tweak_update
//   Combinational tweak update.
//   t      : current tweak (cell 0 = bits [127:120])
//   inv    : 0 -> U(t) = omega(h(t)), 1 -> U^-1(t) = h^-1(omega^-1(t))
//   t_next : updated tweak
module qarma128_tweak_update
   import qarma128_pkg::*;
(
   input  logic [127:0] t,
   input  logic         inv,
   output logic [127:0] t_next
);

   logic [CELL_W-1:0] tc [NCELLS];   // input cells
   logic [CELL_W-1:0] wc [NCELLS];   // input cells after inverse omega

   always_comb begin
      for (int i = 0; i < NCELLS; i++) begin
         tc[i] = t[CELL_W*(NCELLS-1-i) +: CELL_W];
      end
      for (int i = 0; i < NCELLS; i++) begin
         wc[i] = OMEGA_CELLS[NCELLS-1-i] ? omega_inv(tc[i]) : tc[i];
      end
      t_next = '0;
      for (int i = 0; i < NCELLS; i++) begin
         if (inv) begin
            t_next[CELL_W*(NCELLS-1-i) +: CELL_W] = wc[HINV[i]];
         end else begin
            // omega is selected by the output cell position, after h.
            t_next[CELL_W*(NCELLS-1-i) +: CELL_W] =
               OMEGA_CELLS[NCELLS-1-i] ? omega_fwd(tc[H[i]]) : tc[H[i]];
         end
      end
   end

endmodule

// File: rtl/qarma128_tweak_sched.sv
// qarma128_tweak_sched
//   Sequential tweak schedule: loads one tweak and streams ROUNDS round
//   tweaks, beat k = U^k(load) (dir = 0) or U^-k(load) (dir = 1).
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : load stream in, round-tweak stream out (slave modport)
//   All outputs are registered; the update is combinational on tk_data.
module qarma128_tweak_sched
   import qarma128_pkg::*;
#(
   parameter int ROUNDS = 11
)(
   input  logic                   clk,
   input  logic                   rst_n,
   qarma128_tweak_sched_if.slave  bus
);

   localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);
   localparam logic       ONE_RND  = (ROUNDS == 1);

   sched_state_e state_q, state_d;
   logic [127:0] tk_data_q, tk_data_d;
   logic [3:0]   tk_round_q, tk_round_d;
   logic         tk_valid_q, tk_valid_d;
   logic         tk_last_q, tk_last_d;
   logic         load_ready_q, load_ready_d;
   logic         dir_q, dir_d;
   logic [127:0] tk_upd;

   qarma128_tweak_update u_update (
      .t      (tk_data_q),
      .inv    (dir_q),
      .t_next (tk_upd)
   );

   always_comb begin
      state_d    = state_q;
      tk_data_d  = tk_data_q;
      tk_round_d = tk_round_q;
      tk_valid_d = tk_valid_q;
      tk_last_d  = tk_last_q;
      dir_d      = dir_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.load_valid && load_ready_q) begin
               state_d    = ST_RUN;
               tk_data_d  = bus.tweak_in;
               tk_round_d = '0;
               dir_d      = bus.dir;
               tk_valid_d = 1'b1;
               tk_last_d  = ONE_RND;
            end
         end
         ST_RUN: begin
            if (tk_valid_q && bus.tk_ready) begin
               if (tk_round_q == LAST_RND) begin
                  // tk_data/tk_round keep the last beat; only valid drops.
                  state_d    = ST_IDLE;
                  tk_valid_d = 1'b0;
                  tk_last_d  = 1'b0;
               end else begin
                  tk_data_d  = tk_upd;
                  tk_round_d = tk_round_q + 4'd1;
                  tk_last_d  = ((tk_round_q + 4'd1) == LAST_RND);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Registered ready tracks the next state so it rises right after the last beat.
      load_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         tk_data_q    <= '0;
         tk_round_q   <= '0;
         tk_valid_q   <= 1'b0;
         tk_last_q    <= 1'b0;
         load_ready_q <= 1'b1;
         dir_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         tk_data_q    <= tk_data_d;
         tk_round_q   <= tk_round_d;
         tk_valid_q   <= tk_valid_d;
         tk_last_q    <= tk_last_d;
         load_ready_q <= load_ready_d;
         dir_q        <= dir_d;
      end
   end

   assign bus.load_ready = load_ready_q;
   assign bus.tk_valid   = tk_valid_q;
   assign bus.tk_data    = tk_data_q;
   assign bus.tk_round   = tk_round_q;
   assign bus.tk_last    = tk_last_q;

endmodule

// File: tb/tb_qarma128_tweak_sched.sv
module tb_qarma128_tweak_sched;

   localparam int R = 11;
   localparam int HM  [16] = '{6,5,14,15,0,1,2,3,7,12,13,4,8,9,10,11};
   localparam int HIM [16] = '{4,5,6,7,11,1,0,8,12,13,14,15,9,10,2,3};
   localparam int OM  [7]  = '{0,1,3,4,8,11,13};

   typedef struct packed {
      logic [127:0] d;
      logic [3:0]   r;
      logic         l;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   beat_t exp_q [$];

   qarma128_tweak_sched_if bus ();

   qarma128_tweak_sched #(.ROUNDS(R)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (byte-array form) ----------------
   function automatic logic [127:0] m_fwd(input logic [127:0] t);
      logic [7:0] c [16];
      logic [7:0] s [16];
      logic [127:0] o;
      for (int i = 0; i < 16; i++) c[i] = t[127-8*i -: 8];
      for (int i = 0; i < 16; i++) s[i] = c[HM[i]];
      for (int j = 0; j < 7; j++) s[OM[j]] = {s[OM[j]][0] ^ s[OM[j]][2], s[OM[j]][7:1]};
      o = '0;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   function automatic logic [127:0] m_inv(input logic [127:0] t);
      logic [7:0] c [16];
      logic [7:0] s [16];
      logic [127:0] o;
      for (int i = 0; i < 16; i++) c[i] = t[127-8*i -: 8];
      for (int j = 0; j < 7; j++) c[OM[j]] = {c[OM[j]][6:0], c[OM[j]][7] ^ c[OM[j]][1]};
      for (int i = 0; i < 16; i++) s[i] = c[HIM[i]];
      o = '0;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Push expected beats k0..k1 starting from tweak t at round k0.
   task automatic push_from(input logic [127:0] t, input int k0, input int k1, input logic d);
      logic [127:0] cur;
      cur = t;
      for (int k = k0; k <= k1; k++) begin
         exp_q.push_back('{d: cur, r: 4'(k), l: (k == R-1)});
         cur = d ? m_inv(cur) : m_fwd(cur);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst_n && bus.tk_valid && bus.tk_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", {124'd0, bus.tk_round}, 128'hDEAD);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            chk($sformatf("beat%0d_data", e.r), bus.tk_data, e.d);
            chk($sformatf("beat%0d_round", e.r), {124'd0, bus.tk_round}, {124'd0, e.r});
            chk($sformatf("beat%0d_last", e.r), {127'd0, bus.tk_last}, {127'd0, e.l});
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [127:0] t, input logic d);
      int n;
      n = 0;
      while (!bus.load_ready && n < 100) begin
         tick();
         n++;
      end
      if (!bus.load_ready) chk("load_ready_timeout", 128'd0, 128'd1);
      bus.load_valid = 1'b1;
      bus.tweak_in   = t;
      bus.dir        = d;
      tick();
      bus.load_valid = 1'b0;
      chk("load_latency_valid", {127'd0, bus.tk_valid}, 128'd1);
   endtask

   task automatic wait_round(input logic [3:0] k);
      int n;
      n = 0;
      while (!(bus.tk_valid && bus.tk_round == k) && n < 100) begin
         tick();
         n++;
      end
      if (!(bus.tk_valid && bus.tk_round == k)) chk("wait_round_timeout", {124'd0, bus.tk_round}, {124'd0, k});
   endtask

   // Wait until all expected beats are consumed, then check turnaround.
   task automatic drain(input string nm);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      chk({nm, "_drained"}, 128'(exp_q.size()), 128'd0);
      exp_q.delete();
      chk({nm, "_load_ready_after"}, {127'd0, bus.load_ready}, 128'd1);
      chk({nm, "_valid_after"}, {127'd0, bus.tk_valid}, 128'd0);
   endtask

   logic [127:0] rnd, fb [R];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.load_valid = 1'b0;
      bus.tweak_in   = '0;
      bus.dir        = 1'b0;
      bus.tk_ready   = 1'b0;
      rst_n          = 1'b0;
      tick();
      tick();
      chk("rst_load_ready", {127'd0, bus.load_ready}, 128'd1);
      chk("rst_tk_valid", {127'd0, bus.tk_valid}, 128'd0);
      chk("rst_tk_data", bus.tk_data, 128'd0);
      chk("rst_tk_round", {124'd0, bus.tk_round}, 128'd0);
      chk("rst_tk_last", {127'd0, bus.tk_last}, 128'd0);
      rst_n = 1'b1;
      tick();

      // Reset mid-run: accept three beats then reset.
      bus.tk_ready = 1'b1;
      push_from({128{1'b1}}, 0, 2, 1'b0);
      do_load({128{1'b1}}, 1'b0);
      wait_round(4'd2);
      tick();                       // beat 2 accepted on this edge
      bus.tk_ready = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst_three_beats", 128'(exp_q.size()), 128'd0);
      chk("midrst_tk_valid", {127'd0, bus.tk_valid}, 128'd0);
      chk("midrst_tk_data", bus.tk_data, 128'd0);
      chk("midrst_load_ready", {127'd0, bus.load_ready}, 128'd1);
      chk("midrst_tk_round", {124'd0, bus.tk_round}, 128'd0);
      bus.tk_ready = 1'b1;
      tick();
      chk("midrst_no_more_beats", {127'd0, bus.tk_valid}, 128'd0);

      // Zero tweak forward (also confirms restart from round 0 after reset).
      push_from(128'd0, 0, R-1, 1'b0);
      do_load(128'd0, 1'b0);
      drain("zero");

      // Single-cell forward: beat 1 hand-computed.
      exp_q.push_back('{d: 128'h00000000000001000000000000000000, r: 4'd0, l: 1'b0});
      push_from(128'h80000000000000000000000000000000, 1, R-1, 1'b0);
      do_load(128'h00000000000001000000000000000000, 1'b0);
      drain("fwd1");

      // Inverse: beat 1 hand-computed.
      exp_q.push_back('{d: 128'h80000000000000000000000000000000, r: 4'd0, l: 1'b0});
      push_from(128'h00000000000001000000000000000000, 1, R-1, 1'b1);
      do_load(128'h80000000000000000000000000000000, 1'b1);
      drain("inv1");

      // Backpressure with ignored load pulses.
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      fb[0] = rnd;
      for (int k = 1; k < R; k++) fb[k] = m_fwd(fb[k-1]);
      push_from(rnd, 0, R-1, 1'b0);
      do_load(rnd, 1'b0);
      wait_round(4'd2);
      bus.tk_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         bus.load_valid = 1'b1;
         bus.tweak_in   = ~rnd;
         bus.dir        = 1'b1;
         tick();
         chk($sformatf("bp%0d_data", c), bus.tk_data, fb[2]);
         chk($sformatf("bp%0d_round", c), {124'd0, bus.tk_round}, 128'd2);
         chk($sformatf("bp%0d_valid", c), {127'd0, bus.tk_valid}, 128'd1);
         chk($sformatf("bp%0d_load_ready", c), {127'd0, bus.load_ready}, 128'd0);
      end
      bus.load_valid = 1'b0;
      bus.dir        = 1'b0;
      bus.tk_ready   = 1'b1;
      drain("bp");

      // Round trip: forward then inverse from the final forward beat.
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      fb[0] = rnd;
      for (int k = 1; k < R; k++) fb[k] = m_fwd(fb[k-1]);
      push_from(rnd, 0, R-1, 1'b0);
      do_load(rnd, 1'b0);
      drain("rt_fwd");
      for (int k = 0; k < R; k++)
         exp_q.push_back('{d: fb[R-1-k], r: 4'(k), l: (k == R-1)});
      do_load(fb[R-1], 1'b1);
      drain("rt_inv");
      chk("rt_final_equals_orig", bus.tk_data, rnd);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
